// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access sequencer and its arbiter.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MAR,
        ACCESS,
        CAPTURE,
        DONE
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam int unsigned ADDR_W_DEF  = 9;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned RAM_LAT_MIN = 1;
    localparam int unsigned RAM_LAT_MAX = 7;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter between the fetch and data ports.
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic last_grant;

    // bit 0 = fetch, bit 1 = data; a tie goes to the port not served last
    always_comb begin
        grant = '0;
        if (grant_en) begin
            if (fetch_req && data_req) begin
                if (last_grant == PORT_DATA) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end else if (fetch_req) begin
                grant = 2'b01;
            end else if (data_req) begin
                grant = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_DATA;
        end else if (grant_en && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-side sequencer: grants one request at a time and walks it through
// MAR load, a fixed-latency RAM access and (for reads) MDR capture.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic clk,
    input  logic Clear_n,
    input  logic fetch_req,
    input  logic data_req,
    input  logic data_we,
    output logic fetch_done,
    output logic data_done,
    output logic mar_sel,
    output logic MARIn,
    output logic MDRIn,
    output logic Read,
    output logic mem_rd,
    output logic mem_wr,
    output logic busy
);

    if (RAM_LAT < RAM_LAT_MIN || RAM_LAT > RAM_LAT_MAX || ADDR_W == 0 || DATA_W == 0) begin : g_bad_param
        $error("mem_access_ctrl: RAM_LAT must be within 1..7 and widths non-zero");
    end

    localparam logic [2:0] CNT_INIT = 3'(RAM_LAT - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       port;
    logic       is_write;
    logic       grant_en;
    logic [1:0] grant;

    assign grant_en = (state == IDLE);

    mem_rr_arbiter u_arb (
        .clk      (clk),
        .rst_n    (Clear_n),
        .fetch_req(fetch_req),
        .data_req (data_req),
        .grant_en (grant_en),
        .grant    (grant)
    );

    // Outputs are set on the edge entering each state so they align with it.
    always_ff @(posedge clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state      <= IDLE;
            cnt        <= '0;
            port       <= PORT_FETCH;
            is_write   <= 1'b0;
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            mar_sel    <= 1'b0;
            MARIn      <= 1'b0;
            MDRIn      <= 1'b0;
            Read       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        port     <= grant[1];
                        is_write <= grant[1] & data_we;
                        mar_sel  <= grant[1];
                        MARIn    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LOAD_MAR;
                    end
                end
                LOAD_MAR: begin
                    MARIn  <= 1'b0;
                    cnt    <= CNT_INIT;
                    mem_rd <= ~is_write;
                    mem_wr <= is_write;
                    state  <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == 3'd0) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (is_write) begin
                            fetch_done <= (port == PORT_FETCH);
                            data_done  <= (port == PORT_DATA);
                            state      <= DONE;
                        end else begin
                            MDRIn <= 1'b1;
                            Read  <= 1'b1;
                            state <= CAPTURE;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                CAPTURE: begin
                    MDRIn      <= 1'b0;
                    Read       <= 1'b0;
                    fetch_done <= (port == PORT_FETCH);
                    data_done  <= (port == PORT_DATA);
                    state      <= DONE;
                end
                DONE: begin
                    fetch_done <= 1'b0;
                    data_done  <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances with RAM_LAT = 1, 2, 3 checked
// cycle by cycle against a transaction-schedule reference model.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] clear_n   = '0;
    logic [2:0] fetch_req = '0;
    logic [2:0] data_req  = '0;
    logic [2:0] data_we   = '0;
    logic [2:0] fetch_done, data_done, mar_sel, mar_in, mdr_in, rd, mem_rd, mem_wr, busy;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(g + 1)) u_dut (
            .clk       (clk),
            .Clear_n   (clear_n[g]),
            .fetch_req (fetch_req[g]),
            .data_req  (data_req[g]),
            .data_we   (data_we[g]),
            .fetch_done(fetch_done[g]),
            .data_done (data_done[g]),
            .mar_sel   (mar_sel[g]),
            .MARIn     (mar_in[g]),
            .MDRIn     (mdr_in[g]),
            .Read      (rd[g]),
            .mem_rd    (mem_rd[g]),
            .mem_wr    (mem_wr[g]),
            .busy      (busy[g])
        );
    end

    // Reference model: per instance, the active transaction and cycles since grant.
    bit m_act  [3];
    int m_k    [3];
    bit m_port [3];
    bit m_wr   [3];
    bit m_last [3];
    bit m_mar  [3];

    // Cycle (counted from the grant edge) in which the done pulse is visible.
    function automatic int done_at(int i);
        return m_wr[i] ? (i + 1) + 2 : (i + 1) + 3;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!clear_n[i]) begin
                m_act[i]  = 1'b0;
                m_k[i]    = 0;
                m_last[i] = 1'b1;
                m_mar[i]  = 1'b0;
            end else if (m_act[i]) begin
                m_k[i] = m_k[i] + 1;
                if (m_k[i] > done_at(i)) m_act[i] = 1'b0;
            end else if (fetch_req[i] || data_req[i]) begin
                if (fetch_req[i] && data_req[i]) m_port[i] = ~m_last[i];
                else                             m_port[i] = data_req[i];
                m_wr[i]   = m_port[i] & data_we[i];
                m_last[i] = m_port[i];
                m_mar[i]  = m_port[i];
                m_act[i]  = 1'b1;
                m_k[i]    = 1;
            end
        end
    end

    // {fetch_done, data_done, mar_sel, MARIn, MDRIn, Read, mem_rd, mem_wr, busy}
    function automatic logic [8:0] exp_vec(int i);
        logic [8:0] v;
        int k;
        int lat;
        k   = m_k[i];
        lat = i + 1;
        v   = '0;
        v[6] = m_mar[i];
        if (m_act[i]) begin
            v[8] = !m_port[i] && (k == done_at(i));
            v[7] =  m_port[i] && (k == done_at(i));
            v[5] = (k == 1);
            v[4] = !m_wr[i] && (k == lat + 2);
            v[3] = !m_wr[i] && (k == lat + 2);
            v[2] = !m_wr[i] && (k >= 2) && (k <= lat + 1);
            v[1] =  m_wr[i] && (k >= 2) && (k <= lat + 1);
            v[0] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [8:0] obs(int i);
        return {fetch_done[i], data_done[i], mar_sel[i], mar_in[i], mdr_in[i],
                rd[i], mem_rd[i], mem_wr[i], busy[i]};
    endfunction

    task automatic test_reset();
        clear_n = '0; fetch_req = '0; data_req = '0; data_we = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== 9'b0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %b expected %b", i, obs(i), 9'b0);
            end
        end
        clear_n = '1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL idle_after_release[%0d]: got %b expected %b", i, obs(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_fetch_read();
        int done_cyc = -1;
        fetch_req[0] = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if (obs(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL fetch_read c=%0d: got %b expected %b", c, obs(0), exp_vec(0));
            end
            if (fetch_done[0] === 1'b1) begin
                done_cyc = c;
                fetch_req[0] = 1'b0;
            end
        end
        checks++;
        if (done_cyc != 4) begin
            errors++;
            $display("FAIL fetch_done_cycle: got %0d expected %0d", done_cyc, 4);
        end
    endtask

    task automatic test_store();
        int done_cyc = -1;
        int wr_cycles = 0;
        int mdr_cycles = 0;
        data_req[2] = 1'b1;
        data_we[2]  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (obs(2) !== exp_vec(2)) begin
                errors++;
                $display("FAIL store c=%0d: got %b expected %b", c, obs(2), exp_vec(2));
            end
            if (mem_wr[2] === 1'b1) wr_cycles++;
            if (mdr_in[2] === 1'b1) mdr_cycles++;
            if (data_done[2] === 1'b1) begin
                done_cyc = c;
                data_req[2] = 1'b0;
                data_we[2]  = 1'b0;
            end
        end
        checks++;
        if (wr_cycles != 3) begin
            errors++;
            $display("FAIL store_wr_cycles: got %0d expected %0d", wr_cycles, 3);
        end
        checks++;
        if (mdr_cycles != 0) begin
            errors++;
            $display("FAIL store_mdr_cycles: got %0d expected %0d", mdr_cycles, 0);
        end
        checks++;
        if (done_cyc != 5) begin
            errors++;
            $display("FAIL store_done_cycle: got %0d expected %0d", done_cyc, 5);
        end
        checks++;
        if (mar_sel[2] !== 1'b1) begin
            errors++;
            $display("FAIL store_mar_sel: got %b expected %b", mar_sel[2], 1'b1);
        end
    endtask

    task automatic test_round_robin();
        bit order [$];
        bit exp_order [4];
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        fetch_req[1] = 1'b1;
        data_req[1]  = 1'b1;
        for (int c = 1; c <= 80 && order.size() < 4; c++) begin
            data_we[1] = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs(1) !== exp_vec(1)) begin
                errors++;
                $display("FAIL round_robin c=%0d: got %b expected %b", c, obs(1), exp_vec(1));
            end
            if (fetch_done[1] === 1'b1) order.push_back(1'b0);
            if (data_done[1] === 1'b1)  order.push_back(1'b1);
            if (order.size() >= 4) begin
                fetch_req[1] = 1'b0;
                data_req[1]  = 1'b0;
            end
        end
        fetch_req[1] = 1'b0;
        data_req[1]  = 1'b0;
        data_we[1]   = 1'b0;
        checks++;
        if (order.size() != 4) begin
            errors++;
            $display("FAIL round_robin_count: got %0d expected %0d", order.size(), 4);
        end else begin
            for (int t = 0; t < 4; t++) begin
                checks++;
                if (order[t] !== exp_order[t]) begin
                    errors++;
                    $display("FAIL round_robin_order[%0d]: got %0d expected %0d", t, order[t], exp_order[t]);
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        int marin_cyc = -1;
        int done_cyc = -1;
        fetch_req[0] = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (mem_rd[0] === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid_access_seen: got %b expected %b", found, 1'b1);
        end
        clear_n[0] = 1'b0;
        #1;
        checks++;
        if (obs(0) !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid_immediate: got %b expected %b", obs(0), 9'b0);
        end
        @(negedge clk);
        checks++;
        if (obs(0) !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid_held: got %b expected %b", obs(0), 9'b0);
        end
        clear_n[0] = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if (obs(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL reset_mid_restart c=%0d: got %b expected %b", c, obs(0), exp_vec(0));
            end
            if (mar_in[0] === 1'b1 && marin_cyc < 0) marin_cyc = c;
            if (fetch_done[0] === 1'b1) begin
                done_cyc = c;
                fetch_req[0] = 1'b0;
            end
        end
        checks++;
        if (marin_cyc != 1 || done_cyc != 4) begin
            errors++;
            $display("FAIL reset_mid_restart_timing: got marin=%0d done=%0d expected marin=1 done=4",
                     marin_cyc, done_cyc);
        end
    endtask

    task automatic test_drop();
        int done_cyc = -1;
        data_req[1] = 1'b1;
        data_we[1]  = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) data_req[1] = 1'b0;
            checks++;
            if (obs(1) !== exp_vec(1)) begin
                errors++;
                $display("FAIL drop c=%0d: got %b expected %b", c, obs(1), exp_vec(1));
            end
            if (data_done[1] === 1'b1) done_cyc = c;
        end
        checks++;
        if (done_cyc != 5) begin
            errors++;
            $display("FAIL drop_done_cycle: got %0d expected %0d", done_cyc, 5);
        end
        checks++;
        if (busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle_busy: got %b expected %b", busy[1], 1'b0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            fetch_req = 3'($urandom);
            data_req  = 3'($urandom);
            data_we   = 3'($urandom);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL random[%0d] c=%0d: got %b expected %b", i, c, obs(i), exp_vec(i));
                end
            end
        end
        fetch_req = '0;
        data_req  = '0;
        data_we   = '0;
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_store();
        test_round_robin();
        test_reset_mid();
        test_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer and arbiter for the memory-side datapath (MAR, MDR, 512-word RAM). Accepts instruction-fetch and data load/store requests from the control unit. Grants one request at a time, round-robin, and walks it through MAR load, RAM access with a fixed wait, and MDR capture. Signals completion with a one-cycle done pulse per requester.

## Interface
- ADDR_W, 9, RAM/MAR address width (matches MAR Address[8:0])
- DATA_W, 32, bus/MDR width
- RAM_LAT, 1, RAM access cycles; legal range 1..7
- clk  in  1  system clock, rising edge
- Clear_n  in  1  reset; one clock, asynchronous, active-low
- fetch_req  in  1  instruction read request; held high until fetch_done
- data_req  in  1  data access request; held high until data_done
- data_we  in  1  1 = store, 0 = load; sampled at grant, ignored otherwise
- fetch_done  out  1  one-cycle completion pulse, fetch port
- data_done  out  1  one-cycle completion pulse, data port
- mar_sel  out  1  bus-mux address source: 0 = PC, 1 = data-address register
- MARIn  out  1  MAR load enable
- MDRIn  out  1  MDR load enable
- Read  out  1  MDR input mux: 1 = RAM data, 0 = bus
- mem_rd  out  1  RAM read strobe
- mem_wr  out  1  RAM write strobe
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD_MAR, ACCESS, CAPTURE, DONE.
- IDLE: if any request is high, grant at the next edge and go to LOAD_MAR.
  - Latch the granted port and is_write (fetch is always a read; data uses data_we).
  - Set mar_sel for the granted port.
- LOAD_MAR: MARIn = 1 for exactly one cycle. Go to ACCESS and load the wait counter with RAM_LAT-1.
- ACCESS: mem_rd (read) or mem_wr (write) is held high. Decrement the counter each cycle. At zero, a read goes to CAPTURE and a write goes to DONE.
- CAPTURE: MDRIn = 1 and Read = 1 for one cycle, then go to DONE.
- DONE: pulse the done output of the granted port for one cycle, then go to IDLE unconditionally.
- Stores: the control unit has already loaded MDR with the write data before asserting data_req. The controller never drives MDRIn on a write.
- Arbitration: round-robin via a last_grant flag.
  - If both requests are high in IDLE, the port not granted last wins.
  - last_grant resets to "data", so the first tie goes to fetch.
  - With a single request, that port is granted regardless of last_grant.
- mar_sel holds its value from grant until the next grant. It resets to 0.
- Request dropped mid-operation: the operation still completes and the done pulse still fires. No abort path exists.
- Requests and data_we are ignored outside IDLE.
- Counter: 3 bits, unsigned, no wrap. ACCESS lasts exactly RAM_LAT cycles.

## Timing
- Reset: asynchronous entry to IDLE while Clear_n = 0; release is synchronous to clk. Reset values:
  - All outputs are 0 (fetch_done, data_done, mar_sel, MARIn, MDRIn, Read, mem_rd, mem_wr, busy).
  - last_grant = data; counter = 0.
- Reset mid-operation: strobes drop immediately and no done pulse is issued. The requester must re-request.
- Take edge E0 as the edge at which a request is granted.
- Read: LOAD_MAR in the cycle after E0; ACCESS for RAM_LAT cycles; CAPTURE; DONE in cycle 3+RAM_LAT after E0. Total cycles IDLE→IDLE: 4+RAM_LAT.
- Write: DONE in cycle 2+RAM_LAT after E0.
- Back-to-back: minimum one IDLE cycle between a DONE and the next LOAD_MAR.
- All outputs are registered state decodes and are glitch-free. MARIn, MDRIn and the done outputs are never high for more than one consecutive cycle.

## Structure
- Package mem_ctrl_pkg contains:
  - state enum (IDLE, LOAD_MAR, ACCESS, CAPTURE, DONE);
  - port id constants (PORT_FETCH = 0, PORT_DATA = 1);
  - ADDR_W/DATA_W defaults and the RAM_LAT legal-range constants.
- Sub-module mem_rr_arbiter: 2-way round-robin arbiter with its own last_grant flop. Inputs are the two requests and a grant_en (IDLE); output is a one-hot grant.
- FSM and wait counter live in mem_access_ctrl.
- Elaboration-time check: 1 ≤ RAM_LAT ≤ 7.

## Test plan
- Reset, then fetch_req=1 with RAM_LAT=1 → MARIn high in cycle 1, mem_rd in cycle 2, MDRIn+Read in cycle 3, fetch_done in cycle 4, mar_sel=0 throughout.
- data_req=1, data_we=1, RAM_LAT=3 → mem_wr high for exactly 3 cycles, MDRIn never high, data_done in cycle 5, mar_sel=1.
- fetch_req and data_req both held high for 4 transactions → grants alternate fetch, data, fetch, data; each done pulses exactly once per transaction.
- Clear_n pulsed low during ACCESS of a read → all outputs go to 0 immediately, no done pulse; after release with fetch_req still high, a full read restarts from LOAD_MAR.
- data_req dropped right after grant (load, RAM_LAT=2) → sequence completes and data_done fires in cycle 5; the controller then stays in IDLE with busy=0.
